reorder_merger_rd: RTL and testbench

Read-data counterpart to the ECI read splitter. It consumes the per-request sequence entries `{arlen, even_odd}` that the splitter pushes, and pulls 128 B read beats alternately from the two MIB-side read channels (0 = even, 1 = odd). It re-emits the beats on a single AXI R stream in original address order with a regenerated `rlast`. It sits between the two ECI read-response paths and the user-facing AXI read port.

---
 rtl/eci_cmd_defs.sv | 23 ++
 rtl/reorder_merger_rd_out_reg.sv | 65 ++++++
 rtl/reorder_merger_rd.sv | 136 +++++++++++++
 tb/tb_reorder_merger_rd.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eci_cmd_defs.sv
// Shared ECI command definitions: the read-reorder sequence entry and line size
// used by the read splitter and the read-data merger.
package eci_cmd_defs;

  localparam int REORDER_LINE_BYTES = 128;

  // Sequence-queue entry pushed by the splitter; packs as {len, even_odd}.
  typedef struct packed {
    logic [7:0] len;
    logic       even_odd;
  } reorder_seq_t;

  typedef enum logic {
    RM_IDLE   = 1'b0,
    RM_STREAM = 1'b1
  } reorder_state_e;

  // Channel that carries beat i of a request starting on channel sc.
  function automatic logic reorder_chan(input logic sc, input logic beat_lsb);
    return sc ^ beat_lsb;
  endfunction

endpackage

// File: rtl/reorder_merger_rd_out_reg.sv
// Single-entry AXI R output register for the read merger; exposes out_free so
// the merger can accept a new beat in the same cycle the current one drains.
module reorder_merger_out_reg
  import eci_cmd_defs::*;
#(
  parameter int DATA_BITS = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic [1:0]           in_resp,
  input  logic                 in_last,
  input  logic                 out_rready,
  output logic                 out_free,
  output logic [DATA_BITS-1:0] out_data,
  output logic [1:0]           out_resp,
  output logic                 out_last,
  output logic                 out_valid
);

  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0]           resp_q, resp_d;

  assign out_free = ~valid_q | out_rready;

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    resp_d  = resp_q;
    if (load) begin
      valid_d = 1'b1;
      last_d  = in_last;
      data_d  = in_data;
      resp_d  = in_resp;
    end else if (out_rready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge aclk) begin
    data_q <= data_d;
    resp_q <= resp_d;
  end

  assign out_data  = data_q;
  assign out_resp  = resp_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/reorder_merger_rd.sv
// Merges even/odd ECI read-response channels back into original AXI R order.
// Optional rlast checker enabled by defining REORDER_MERGER_CHECK_EN.
module reorder_merger_rd
  import eci_cmd_defs::*;
#(
  parameter int DATA_BITS = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      mux_r_valid,
  output logic                      mux_r_ready,
  input  logic [8:0]                mux_r_data,
  input  logic [1:0][DATA_BITS-1:0] axi_in_rdata,
  input  logic [1:0][1:0]           axi_in_rresp,
  input  logic [1:0]                axi_in_rlast,
  input  logic [1:0]                axi_in_rvalid,
  output logic [1:0]                axi_in_rready,
  output logic [DATA_BITS-1:0]      axi_out_rdata,
  output logic [1:0]                axi_out_rresp,
  output logic                      axi_out_rlast,
  output logic                      axi_out_rvalid,
  input  logic                      axi_out_rready,
  output logic                      err
);

  reorder_state_e state_q, state_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           sc_q, sc_d;
  logic           ch;
  logic           out_free;
  logic           beat_fire;
  logic           last_beat;
  logic           mux_fire;
  reorder_seq_t   seq_in;

  assign seq_in    = reorder_seq_t'(mux_r_data);
  assign ch        = reorder_chan(sc_q, cnt_q[0]);
  assign beat_fire = (state_q == RM_STREAM) && axi_in_rvalid[ch] && out_free;
  assign last_beat = beat_fire && (cnt_q == len_q);
  assign mux_fire  = mux_r_valid && mux_r_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= RM_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RM_IDLE:   if (mux_fire) state_d = RM_STREAM;
      RM_STREAM: if (last_beat) state_d = mux_r_valid ? RM_STREAM : RM_IDLE;
      default:   state_d = RM_IDLE;
    endcase
  end

  // Taking the next entry on the final beat keeps request boundaries bubble-free.
  always_comb begin
    mux_r_ready   = 1'b0;
    axi_in_rready = 2'b00;
    case (state_q)
      RM_IDLE: mux_r_ready = 1'b1;
      RM_STREAM: begin
        axi_in_rready[ch] = out_free;
        mux_r_ready       = last_beat;
      end
      default: mux_r_ready = 1'b0;
    endcase
  end

  always_comb begin
    len_d = len_q;
    sc_d  = sc_q;
    cnt_d = cnt_q;
    if (mux_fire) begin
      len_d = seq_in.len;
      sc_d  = seq_in.even_odd;
      cnt_d = 8'd0;
    end else if (beat_fire) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      len_q <= 8'd0;
      sc_q  <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      len_q <= len_d;
      sc_q  <= sc_d;
      cnt_q <= cnt_d;
    end
  end

  reorder_merger_out_reg #(
    .DATA_BITS(DATA_BITS)
  ) u_out_reg (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (beat_fire),
    .in_data   (axi_in_rdata[ch]),
    .in_resp   (axi_in_rresp[ch]),
    .in_last   (cnt_q == len_q),
    .out_rready(axi_out_rready),
    .out_free  (out_free),
    .out_data  (axi_out_rdata),
    .out_resp  (axi_out_rresp),
    .out_last  (axi_out_rlast),
    .out_valid (axi_out_rvalid)
  );

`ifdef REORDER_MERGER_CHECK_EN
  logic err_q, err_d;
  logic exp_last;

  // A channel's last beat is either of the request's final two beats.
  always_comb begin
    exp_last = (cnt_q == len_q) || (({1'b0, cnt_q} + 9'd1) == {1'b0, len_q});
    err_d    = err_q;
    if (beat_fire && (axi_in_rlast[ch] != exp_last)) err_d = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_rlast;
  assign unused_rlast = ^axi_in_rlast;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_reorder_merger_rd.sv
// Randomized bench for reorder_merger_rd: a beat-order scoreboard built from the
// request list, plus directed latency, bubble, stall-hold and reset scenarios.
module tb_reorder_merger_rd;

  localparam int DW = 64;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          in_last;
    logic          out_last;
    logic          bad;
  } beat_t;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 mux_r_valid = 1'b0;
  logic                 mux_r_ready;
  logic [8:0]           mux_r_data = '0;
  logic [1:0][DW-1:0]   in_rdata = '0;
  logic [1:0][1:0]      in_rresp = '0;
  logic [1:0]           in_rlast = '0;
  logic [1:0]           in_rvalid = '0;
  logic [1:0]           in_rready;
  logic [DW-1:0]        out_rdata;
  logic [1:0]           out_rresp;
  logic                 out_rlast;
  logic                 out_rvalid;
  logic                 out_rready = 1'b0;
  logic                 err;

  always #5 aclk = ~aclk;

  reorder_merger_rd #(.DATA_BITS(DW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .mux_r_valid   (mux_r_valid),
    .mux_r_ready   (mux_r_ready),
    .mux_r_data    (mux_r_data),
    .axi_in_rdata  (in_rdata),
    .axi_in_rresp  (in_rresp),
    .axi_in_rlast  (in_rlast),
    .axi_in_rvalid (in_rvalid),
    .axi_in_rready (in_rready),
    .axi_out_rdata (out_rdata),
    .axi_out_rresp (out_rresp),
    .axi_out_rlast (out_rlast),
    .axi_out_rvalid(out_rvalid),
    .axi_out_rready(out_rready),
    .err           (err)
  );

  beat_t      chq0[$];
  beat_t      chq1[$];
  beat_t      expq[$];
  logic [8:0] entq[$];

  int   n_vec = 0;
  int   n_bad = 0;
  int   p_in = 100;
  int   p_out = 100;
  bit   watch_ch1 = 1'b0;
  logic err_exp = 1'b0;
  bit   stall_prev = 1'b0;
  bit   infire_prev = 1'b0;
  bit   f0, f1, fm;
  int   cyc = 0;
  int   first_out, last_out, n_out;
  logic [DW-1:0] snap_data;
  logic [1:0]    snap_resp;
  logic          snap_last;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat i of a request goes to channel even_odd ^ (i odd), and emerges in order i.
  task automatic add_entry(input int len, input bit eo, input bit bad_first);
    beat_t b;
    logic [7:0] l8;
    l8 = len[7:0];
    entq.push_back({l8, eo});
    for (int i = 0; i <= len; i++) begin
      b.data     = {$urandom, $urandom};
      b.resp     = 2'($urandom);
      b.in_last  = (i == len) || (i + 1 == len);
      b.out_last = (i == len);
      b.bad      = 1'b0;
      if (bad_first && i == 0) begin
        b.in_last = ~b.in_last;
        b.bad     = 1'b1;
      end
      expq.push_back(b);
      if (((i % 2) == 1) ^ eo) chq1.push_back(b);
      else                     chq0.push_back(b);
    end
  endtask

  task automatic drive();
    if (f0) void'(chq0.pop_front());
    if (f1) void'(chq1.pop_front());
    if (fm) void'(entq.pop_front());
    if (!in_rvalid[0] || f0) begin
      in_rvalid[0] = (chq0.size() > 0) && ($urandom_range(99) < p_in);
      if (in_rvalid[0]) begin
        in_rdata[0] = chq0[0].data;
        in_rresp[0] = chq0[0].resp;
        in_rlast[0] = chq0[0].in_last;
      end
    end
    if (!in_rvalid[1] || f1) begin
      in_rvalid[1] = (chq1.size() > 0) && ($urandom_range(99) < p_in);
      if (in_rvalid[1]) begin
        in_rdata[1] = chq1[0].data;
        in_rresp[1] = chq1[0].resp;
        in_rlast[1] = chq1[0].in_last;
      end
    end
    if (!mux_r_valid || fm) begin
      mux_r_valid = (entq.size() > 0) && ($urandom_range(99) < p_in);
      if (mux_r_valid) mux_r_data = entq[0];
    end
    out_rready = ($urandom_range(99) < p_out);
  endtask

  task automatic cycle();
    beat_t e;
    @(negedge aclk);
    cyc++;
    chk("err", err, err_exp);
    if (stall_prev) begin
      chk("hold_vld", out_rvalid, 1);
      chk("hold_data", out_rdata, snap_data);
      chk("hold_resp", out_rresp, snap_resp);
      chk("hold_last", out_rlast, snap_last);
    end
    if (infire_prev) chk("latency", out_rvalid, 1);
    if (watch_ch1) chk("ch1_idle", in_rready[1], 0);
    if (out_rvalid && out_rready) begin
      if (expq.size() == 0) chk("extra_beat", out_rvalid, 0);
      else begin
        e = expq.pop_front();
        chk("rdata", out_rdata, e.data);
        chk("rresp", out_rresp, e.resp);
        chk("rlast", out_rlast, e.out_last);
      end
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      n_out++;
    end
    stall_prev = out_rvalid && !out_rready;
    snap_data  = out_rdata;
    snap_resp  = out_rresp;
    snap_last  = out_rlast;
    f0 = in_rvalid[0] && in_rready[0];
    f1 = in_rvalid[1] && in_rready[1];
    fm = mux_r_valid && mux_r_ready;
    infire_prev = f0 || f1;
`ifdef REORDER_MERGER_CHECK_EN
    if (f0 && chq0[0].bad) err_exp = 1'b1;
    if (f1 && chq1[0].bad) err_exp = 1'b1;
`endif
    @(posedge aclk);
    #1;
    drive();
  endtask

  task automatic run(input int budget);
    int k;
    first_out = -1;
    n_out = 0;
    f0 = 0; f1 = 0; fm = 0;
    @(posedge aclk);
    #1;
    drive();
    k = 0;
    while ((expq.size() != 0 || entq.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) chk("timeout", expq.size(), 0);
    repeat (3) cycle();
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_rvalid", out_rvalid, 0);
    chk("rst_rlast", out_rlast, 0);
    chk("rst_in_rready", in_rready, 0);
    chk("rst_err", err, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("idle_mux_ready", mux_r_ready, 1);

    // Single beat on channel 0; channel 1 must never be asked.
    watch_ch1 = 1'b1;
    add_entry(0, 1'b0, 1'b0);
    run(50);
    chk("len0_beats", n_out, 1);
    watch_ch1 = 1'b0;

    add_entry(3, 1'b1, 1'b0);
    run(50);
    chk("len3_beats", n_out, 4);
    chk("len3_no_bubble", last_out - first_out, 3);

    add_entry(1, 1'b0, 1'b0);
    add_entry(2, 1'b1, 1'b0);
    run(50);
    chk("b2b_beats", n_out, 5);
    chk("b2b_no_bubble", last_out - first_out, 4);

    p_in = 70;
    p_out = 60;
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 4; j++) add_entry($urandom_range(9), 1'($urandom), 1'b0);
      run(2000);
    end

    p_in = 100;
    p_out = 50;
    add_entry(255, 1'($urandom), 1'b0);
    run(3000);
    chk("len255_beats", n_out, 256);
    p_out = 100;

`ifdef REORDER_MERGER_CHECK_EN
    add_entry(3, 1'b0, 1'b1);
    run(50);
    chk("chk_beats", n_out, 4);
    chk("err_sticky", err, 1);
`endif

    // Reset after two of four output beats.
    add_entry(3, 1'b0, 1'b0);
    first_out = -1;
    n_out = 0;
    f0 = 0; f1 = 0; fm = 0;
    @(posedge aclk);
    #1;
    drive();
    for (int k = 0; k < 50 && n_out < 2; k++) cycle();
    chk("pre_reset_beats", n_out, 2);
    aresetn = 1'b0;
    #1;
    chk("async_rvalid", out_rvalid, 0);
    chk("async_in_rready", in_rready, 0);
    chk("async_err", err, 0);
    chq0.delete();
    chq1.delete();
    expq.delete();
    entq.delete();
    in_rvalid = '0;
    mux_r_valid = 1'b0;
    err_exp = 1'b0;
    stall_prev = 1'b0;
    infire_prev = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    add_entry(0, 1'b1, 1'b0);
    run(50);
    chk("post_reset_beats", n_out, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
